data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
// PURPOSE
//  Next-generation data memory for the multicycle MIPS datapath.
//  - Byte-addressed; byte/half/word access; sign/zero-extended loads.
//  - Configurable access latency; one-request-at-a-time handshake.
//  - Flags misaligned, out-of-range and malformed requests.
//  - Sits between the ALUOut/B registers and the MDR; the control FSM stalls until ready.
// PARAMETERS
//  DEPTH      256  number of 32-bit words stored
//  ADDR_W     32   width of the byte address port
//  LATENCY    2    cycles from accepted request to ready; legal range >=1
//  INIT_FILE  ""   hex file loaded with $readmemh at time 0; "" = no preload
// PORTS
//  clk      in   1       single clock, rising edge
//  reset    in   1       synchronous, active-high
//  address  in   ADDR_W  byte address of the access
//  dataIn   in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  memRead  in   1       load request
//  memWrite in   1       store request
//  size     in   2       00 byte, 01 half, 10 word, 11 reserved
//  signExt  in   1       1 = sign-extend byte/half loads; 0 = zero-extend
//  dataOut  out  32      load result, valid while ready=1, held until next response
//  ready    out  1       one-cycle pulse: access completed (or rejected)
//  error    out  1       qualified by ready: request rejected, no side effect
// BEHAVIOUR
//  - Reset values: dataOut=0, ready=0, error=0, state=IDLE, latency counter=0.
//  - Reset does not clear array contents.
//  - Reset mid-operation aborts the access; a pending store is discarded.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: on a cycle with memRead|memWrite, latch address, size, signExt, dataIn and op.
//    - Go to BUSY with counter=LATENCY-1.
//    - If LATENCY=1, go directly to RESP.
//  - BUSY: decrement the counter; enter RESP when it reaches 1.
//    - memRead/memWrite are ignored while BUSY/RESP; the requester holds them until ready.
//  - RESP: ready=1 for exactly one cycle, then return to IDLE.
//    - The next request is accepted no earlier than the cycle after RESP.
//    - Request sampled at edge t -> ready high in cycle t+LATENCY.
//  - Store commit: at the clock edge ending RESP, only for the addressed byte lanes.
//  - Load: data is read from the latched address and driven on dataOut during RESP.
//  - Endianness: little-endian. Byte at addr a sits in word a>>2, lane a[1:0].
//  - Load extraction:
//    - byte -> bits 8*a[1:0]+:8
//    - half -> lane pair a[1]
//    - extended to 32 bits per signExt
//  - Error (ready=1, error=1, no write, dataOut=0) when any of:
//    - memRead and memWrite both high at acceptance
//    - size==11
//    - half with a[0]=1, or word with a[1:0]!=0
//    - (address>>2) >= DEPTH
//  - A successful response drives error=0.
//  - Array reads are registered internally; no combinational path from the request inputs to dataOut.
// STRUCTURE
//  - Package mem_pkg holds:
//    - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
//    - FSM state encodings IDLE/BUSY/RESP
//  - Sub-module lane_align (combinational):
//    - store: generates 4-bit byte strobe and replicated write data from size/a[1:0]
//    - load: extracts and extends load data
//    - flags misalignment
//  - Top level: FSM, latency counter, request latches, byte-strobed array.
// TESTING
//  1. Word store 0xDEADBEEF @0x40, word load @0x40 -> dataOut=0xDEADBEEF, error=0.
//  2. After (1), byte loads @0x41:
//     - signExt=1 -> 0xFFFFFFBE; signExt=0 -> 0x000000BE.
//     - Half load @0x42, signExt=0 -> 0x0000DEAD.
//  3. Byte store 0x11 @0x43, then word load @0x40 -> 0x11ADBEEF (other lanes intact).
//  4. Word load @0x42 -> ready with error=1, dataOut=0; word @0x40 still 0x11ADBEEF.
//     - size=11, and address 4*DEPTH, also give error=1.
//  5. LATENCY=3, request at edge t -> ready exactly in cycle t+3, one cycle wide.
//     - Repeat with LATENCY=1 -> ready in cycle t+1.
//  6. Store 0x12345678 @0x80, assert reset during BUSY:
//     - outputs return to 0
//     - later load @0x80 returns its prior value
//     - memRead&memWrite together -> error=1

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and the latched request payload for the data memory controller.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic        op_wr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/lane_align.sv
// Little-endian byte-lane steering: store strobes/replicated data, load extraction/extension,
// and alignment/size legality flags.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_sign_ext,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_wstrb_c,
  output logic [31:0] o_wdata_c,
  output logic [31:0] o_rdata_c,
  output logic        o_misalign_c,
  output logic        o_bad_size_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(i_rword >> {i_addr_lo, 3'b000});
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    o_wstrb_c    = 4'b0000;
    o_wdata_c    = 32'h0;
    o_rdata_c    = 32'h0;
    o_misalign_c = 1'b0;
    o_bad_size_c = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_wstrb_c = 4'b0001 << i_addr_lo;
        o_wdata_c = {4{i_wdata[7:0]}};
        o_rdata_c = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_misalign_c = i_addr_lo[0];
        o_wstrb_c    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_c    = {2{i_wdata[15:0]}};
        o_rdata_c    = {{16{i_sign_ext & w_half[15]}}, w_half};
      end
      SZ_WORD: begin
        o_misalign_c = |i_addr_lo;
        o_wstrb_c    = 4'b1111;
        o_wdata_c    = i_wdata;
        o_rdata_c    = i_rword;
      end
      default: o_bad_size_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory for the multicycle MIPS datapath: fixed-latency
// request/ready handshake, byte-strobed stores, extended loads, request rejection.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       dataIn,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [1:0]        size,
  input  logic              signExt,
  output logic [31:0]       dataOut,
  output logic              ready,
  output logic              error
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;

  logic [ADDR_W-1:0] r_addr;
  req_t              r_req;
  logic              r_reject;

  logic              w_idle;
  logic              w_req_valid;
  req_t              w_req_in;
  logic [ADDR_W-1:0] w_addr;
  req_t              w_req;
  logic [IDX_W-1:0]  w_idx;
  logic              w_oor;
  logic              w_reject;
  logic              w_enter_resp;
  logic              w_we;

  logic [31:0]       w_rword;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;
  logic              w_misalign;
  logic              w_bad_size;

  logic [31:0]       r_mem [DEPTH];

  assign w_idle      = (r_state == IDLE);
  assign w_req_valid = memRead | memWrite;

  always_comb begin
    w_req_in          = '0;
    w_req_in.op_wr    = memWrite;
    w_req_in.size     = size;
    w_req_in.sign_ext = signExt;
    w_req_in.wdata    = dataIn;
  end

  // While idle the live inputs are evaluated so LATENCY=1 can respond on the next cycle.
  assign w_addr  = w_idle ? address : r_addr;
  assign w_req   = w_idle ? w_req_in : r_req;
  assign w_idx   = w_addr[IDX_W+1:2];
  assign w_oor   = (64'(w_addr >> 2) >= 64'(DEPTH));
  assign w_rword = r_mem[w_idx];

  lane_align u_align (
    .i_size       (w_req.size),
    .i_addr_lo    (w_addr[1:0]),
    .i_sign_ext   (w_req.sign_ext),
    .i_wdata      (w_req.wdata),
    .i_rword      (w_rword),
    .o_wstrb_c    (w_wstrb),
    .o_wdata_c    (w_wdata),
    .o_rdata_c    (w_rdata),
    .o_misalign_c (w_misalign),
    .o_bad_size_c (w_bad_size)
  );

  assign w_reject = w_idle ? ((memRead & memWrite) | w_bad_size | w_misalign | w_oor)
                           : r_reject;

  // FSM state and latency counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req_valid) begin
          if (LATENCY <= 1) begin
            w_next_state = RESP;
            w_cnt_next   = '0;
          end else begin
            w_next_state = BUSY;
            w_cnt_next   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_next_state = RESP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_enter_resp = (w_next_state == RESP);

  // Request capture on acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_req    <= '0;
      r_reject <= 1'b0;
    end else if (w_idle && w_req_valid) begin
      r_addr   <= address;
      r_req    <= w_req_in;
      r_reject <= w_reject;
    end
  end

  // Response outputs; stores leave dataOut holding the previous load result
  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut <= 32'h0;
      ready   <= 1'b0;
      error   <= 1'b0;
    end else begin
      ready <= w_enter_resp;
      if (w_enter_resp) begin
        error <= w_reject;
        if (w_reject) begin
          dataOut <= 32'h0;
        end else if (!w_req.op_wr) begin
          dataOut <= w_rdata;
        end
      end else begin
        error <= 1'b0;
      end
    end
  end

  // Store commits on the edge that ends RESP; a reset on that edge discards it.
  assign w_we = (r_state == RESP) & r_req.op_wr & ~r_reject & ~reset;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wstrb[i]) r_mem[r_addr[IDX_W+1:2]][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

endmodule
